// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready load and enable-gated shifting.
// Emits frame_start with the first bit and done with the last; supports gapless frames.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             done,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             sout_d, sout_valid_d, frame_start_d, done_d;
    logic             last, accept;

    assign last      = (state == SHIFT) && en && (cnt == CNT_LAST);
    assign din_ready = (state == IDLE) || last;
    assign accept    = din_valid && din_ready;
    assign busy      = (state == SHIFT);

    always_comb begin
        state_d       = state;
        shreg_d       = shreg;
        cnt_d         = cnt;
        sout_d        = sout;
        sout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        done_d        = 1'b0;

        if (state == SHIFT && en) begin
            sout_valid_d  = 1'b1;
            frame_start_d = (cnt == '0);
            cnt_d         = cnt + CNT_ONE;
            if (MSB_FIRST) begin
                sout_d  = shreg[WIDTH-1];
                shreg_d = {shreg[WIDTH-2:0], 1'b0};
            end else begin
                sout_d  = shreg[0];
                shreg_d = {1'b0, shreg[WIDTH-1:1]};
            end
            if (last) begin
                done_d  = 1'b1;
                state_d = IDLE;
                cnt_d   = '0;
            end
        end

        // A load on the last-bit edge overrides the return to IDLE.
        if (accept) begin
            shreg_d = din;
            cnt_d   = '0;
            state_d = SHIFT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            shreg       <= shreg_d;
            cnt         <= cnt_d;
            sout        <= sout_d;
            sout_valid  <= sout_valid_d;
            frame_start <= frame_start_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer.
// Runs an MSB-first and an LSB-first instance side by side on shared stimulus.
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         din_valid = 1'b0;
  logic [W-1:0] din = '0;

  logic m_ready, m_sout, m_sv, m_fs, m_done, m_busy;
  logic l_ready, l_sout, l_sv, l_fs, l_done, l_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .din_valid(din_valid),
    .din_ready(m_ready), .sout(m_sout), .sout_valid(m_sv),
    .frame_start(m_fs), .done(m_done), .busy(m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .din_valid(din_valid),
    .din_ready(l_ready), .sout(l_sout), .sout_valid(l_sv),
    .frame_start(l_fs), .done(l_done), .busy(l_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    #1;
    got = {m_sout, m_sv, m_fs, m_done, m_busy, m_ready};
    checks++;
    if (got !== 6'b000001) begin
      errors++;
      $display("FAIL reset_init got=%b exp=%b", got, 6'b000001);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    got = {m_sout, m_sv, m_fs, m_done, m_busy, m_ready};
    checks++;
    if (got !== 6'b000001) begin
      errors++;
      $display("FAIL reset_release got=%b exp=%b", got, 6'b000001);
    end
    din = 8'hFF;
    din_valid = 1'b1;
    en = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    got = {m_sout, m_sv, m_fs, m_done, m_busy, m_ready};
    checks++;
    if (got !== 6'b111010) begin
      errors++;
      $display("FAIL reset_prefire got=%b exp=%b", got, 6'b111010);
    end
    #2;
    rst = 1'b1;
    #1;
    got = {m_sout, m_sv, m_fs, m_done, m_busy, m_ready};
    checks++;
    if (got !== 6'b000001) begin
      errors++;
      $display("FAIL reset_async got=%b exp=%b", got, 6'b000001);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w;
    logic [4:0]   got, exp;
    w = 8'hB4;
    din = w;
    din_valid = 1'b1;
    en = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if ({m_busy, m_sv} !== 2'b10) begin
      errors++;
      $display("FAIL msb_accept got=%b exp=%b",
               {m_busy, m_sv}, 2'b10);
    end
    for (int k = 0; k < W; k++) begin
      tick();
      got = {m_sout, m_sv, m_fs, m_done, m_busy};
      exp = {w[W-1-k], 1'b1, k == 0, k == W-1, k < W-1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL msb_bit%0d got=%b exp=%b", k, got, exp);
      end
    end
    tick();
    got = {m_sout, m_sv, m_done, m_busy, m_ready};
    checks++;
    if (got !== 5'b00001) begin
      errors++;
      $display("FAIL msb_idle got=%b exp=%b", got, 5'b00001);
    end
  endtask

  task automatic test_lsb_first();
    logic [W-1:0] w;
    logic [4:0]   got, exp;
    w = 8'hB4;
    din = w;
    din_valid = 1'b1;
    en = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      tick();
      got = {l_sout, l_sv, l_fs, l_done, l_busy};
      exp = {w[k], 1'b1, k == 0, k == W-1, k < W-1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL lsb_bit%0d got=%b exp=%b", k, got, exp);
      end
    end
    tick();
    got = {l_sout, l_sv, l_done, l_busy, l_ready};
    checks++;
    if (got !== 5'b10001) begin
      errors++;
      $display("FAIL lsb_idle got=%b exp=%b", got, 5'b10001);
    end
  endtask

  task automatic test_enable_gaps();
    logic [W-1:0] w;
    logic [4:0]   got, exp;
    logic         last_bit;
    int           idx;
    w = 8'hB4;
    din = w;
    din_valid = 1'b1;
    en = 1'b1;
    tick();
    din_valid = 1'b0;
    idx = 0;
    last_bit = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      en = !(e == 3 || e == 4);
      tick();
      if (en) begin
        exp = {w[W-1-idx], 1'b1, idx == 0,
               idx == W-1, idx < W-1};
        last_bit = w[W-1-idx];
        idx++;
      end else begin
        exp = {last_bit, 4'b0001};
      end
      got = {m_sout, m_sv, m_fs, m_done, m_busy};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL gap_edge%0d got=%b exp=%b", e, got, exp);
      end
    end
    en = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] seq;
    logic [4:0]     got, exp;
    seq = 16'hB43C;
    din = 8'hB4;
    din_valid = 1'b1;
    en = 1'b1;
    tick();
    din = 8'h3C;
    for (int k = 0; k < 2*W; k++) begin
      if (k == 3) begin
        checks++;
        if (m_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_mid got=%b exp=0", m_ready);
        end
      end
      if (k == 7) begin
        checks++;
        if (m_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_last got=%b exp=1", m_ready);
        end
      end
      tick();
      if (k == 7)
        din_valid = 1'b0;
      got = {m_sout, m_sv, m_fs, m_done, m_busy};
      exp = {seq[2*W-1-k], 1'b1, k == 0 || k == 8,
             k == 7 || k == 15, k < 15};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL b2b_bit%0d got=%b exp=%b", k, got, exp);
      end
    end
    tick();
  endtask

  task automatic test_robustness();
    logic [W-1:0] w;
    logic [5:0]   got6;
    logic [4:0]   got, exp;
    w = 8'h5A;
    din = w;
    din_valid = 1'b1;
    en = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        din = 8'hFF;
        din_valid = 1'b1;
      end else if (k == 2) begin
        din = 8'h00;
        din_valid = 1'b0;
      end
      tick();
      got = {m_sout, m_sv, m_fs, m_done, m_busy};
      exp = {w[W-1-k], 1'b1, k == 0, 1'b0, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rob_bit%0d got=%b exp=%b", k, got, exp);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    got6 = {m_sout, m_sv, m_fs, m_done, m_busy, m_ready};
    checks++;
    if (got6 !== 6'b000001) begin
      errors++;
      $display("FAIL rob_abort got=%b exp=%b", got6, 6'b000001);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      got = {m_sv, m_fs, m_done, m_busy, m_ready};
      checks++;
      if (got !== 5'b00001) begin
        errors++;
        $display("FAIL rob_quiet%0d got=%b exp=%b",
                 k, got, 5'b00001);
      end
    end
    w = 8'hC3;
    din = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      tick();
      got = {m_sout, m_sv, m_fs, m_done, m_busy};
      exp = {w[W-1-k], 1'b1, k == 0, k == W-1, k < W-1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL rob_new%0d got=%b exp=%b", k, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_enable_gaps();
    test_back_to_back();
    test_robustness();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
